// File: rtl/apb_arb_pkg.sv
// Shared types and defaults for the APB command arbiter.
package apb_arb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_ISSUE = 4'b0010,
    ST_WAIT  = 4'b0100,
    ST_RESP  = 4'b1000
  } arb_state_e;

  localparam logic [7:0] RD_FLAG = 8'h00;
  localparam logic [7:0] WR_FLAG = 8'h01;

  localparam int unsigned DEF_NUM_REQ        = 4;
  localparam int unsigned DEF_RW_WIDTH       = 8;
  localparam int unsigned DEF_ADDR_WIDTH     = 16;
  localparam int unsigned DEF_DATA_WIDTH     = 32;
  localparam int unsigned DEF_TIMEOUT_CYC    = 16;

  // Counter only needs to reach TIMEOUT_CYC-1; keep at least one bit.
  function automatic int unsigned tmo_cnt_w(input int unsigned cyc);
    return (cyc >= 2) ? $clog2(cyc) : 1;
  endfunction

  localparam int unsigned DEF_TMO_CNT_W = tmo_cnt_w(DEF_TIMEOUT_CYC);

endpackage

// File: rtl/apb_rr_pick.sv
// Combinational round-robin picker: first requester above last_gnt, wrapping.
module apb_rr_pick
  import apb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned GNT_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GNT_W-1:0]   last_gnt,
  output logic [GNT_W-1:0]   gnt,
  output logic               any_req
);

  int unsigned idx;

  always_comb begin
    gnt     = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (32'(last_gnt) + i) % NUM_REQ;
      if (!any_req && req[idx]) begin
        gnt     = GNT_W'(idx);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_cmd_arbiter.sv
// Round-robin sharing of one APB command master among NUM_REQ requesters,
// with completion monitoring and a per-transfer timeout.
module apb_cmd_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = DEF_NUM_REQ,
  parameter int unsigned CMD_RW_WIDTH   = DEF_RW_WIDTH,
  parameter int unsigned CMD_ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned CMD_DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned CMD_WIDTH      = CMD_RW_WIDTH + CMD_ADDR_WIDTH + CMD_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYC    = DEF_TIMEOUT_CYC
) (
  input  logic                         pclk_i,
  input  logic                         prst_n_i,
  input  logic [NUM_REQ-1:0]           req_vld_i,
  input  logic [NUM_REQ*CMD_WIDTH-1:0] req_cmd_i,
  output logic [NUM_REQ-1:0]           req_rdy_o,
  output logic [NUM_REQ-1:0]           rsp_vld_o,
  output logic [CMD_DATA_WIDTH-1:0]    rsp_data_o,
  output logic                         rsp_err_o,
  output logic [CMD_WIDTH-1:0]         m_cmd_o,
  output logic                         m_cmd_vld_o,
  input  logic                         m_cmd_rdy_i,
  input  logic                         apb_psel_i,
  input  logic                         apb_penable_i,
  input  logic                         apb_pready_i,
  input  logic                         apb_pslverr_i,
  input  logic [CMD_DATA_WIDTH-1:0]    apb_prdata_i,
  output logic                         busy_o
);

  localparam int unsigned      GNT_W    = $clog2(NUM_REQ);
  localparam int unsigned      CNT_W    = tmo_cnt_w(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  arb_state_e                  state_q, state_d;
  logic [CMD_WIDTH-1:0]        cmd_buf_q, cmd_buf_d, cmd_sel;
  logic [GNT_W-1:0]            gnt_q, gnt_d, last_gnt_q, last_gnt_d, pick_gnt;
  logic                        pick_any;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [CMD_DATA_WIDTH-1:0]   data_q, data_d;
  logic                        err_q, err_d;
  logic                        beat;

  apb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .GNT_W   (GNT_W)
  ) u_pick (
    .req      (req_vld_i),
    .last_gnt (last_gnt_q),
    .gnt      (pick_gnt),
    .any_req  (pick_any)
  );

  assign cmd_sel = req_cmd_i[32'(pick_gnt) * CMD_WIDTH +: CMD_WIDTH];
  assign beat    = apb_psel_i & apb_penable_i & apb_pready_i;

  always_comb begin
    state_d    = state_q;
    cmd_buf_d  = cmd_buf_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    err_d      = err_q;
    req_rdy_o  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          req_rdy_o[pick_gnt] = 1'b1;
          cmd_buf_d           = cmd_sel;
          gnt_d               = pick_gnt;
          state_d             = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (m_cmd_rdy_i) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A beat on the last allowed cycle still counts as a real completion.
        if (beat) begin
          data_d  = apb_prdata_i;
          err_d   = apb_pslverr_i;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        last_gnt_d = gnt_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk_i) begin
    if (!prst_n_i) begin
      state_q    <= ST_IDLE;
      cmd_buf_q  <= '0;
      gnt_q      <= '0;
      last_gnt_q <= GNT_W'(NUM_REQ - 1);
      cnt_q      <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_buf_q  <= cmd_buf_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      err_q      <= err_d;
    end
  end

  assign m_cmd_o     = cmd_buf_q;
  assign m_cmd_vld_o = (state_q == ST_ISSUE);
  assign rsp_vld_o   = (state_q == ST_RESP) ? (NUM_REQ'(1) << gnt_q) : '0;
  assign rsp_data_o  = data_q;
  assign rsp_err_o   = err_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_apb_cmd_arbiter.sv
// Self-checking bench for apb_cmd_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level model.
module tb_apb_cmd_arbiter;

  localparam int unsigned NR  = 4;
  localparam int unsigned RW  = 8;
  localparam int unsigned AW  = 16;
  localparam int unsigned DW  = 32;
  localparam int unsigned CW  = RW + AW + DW;
  localparam int          TMO = 16;

  logic              pclk = 1'b0;
  logic              prst_n;
  logic [NR-1:0]     req_vld, req_rdy, rsp_vld;
  logic [NR*CW-1:0]  req_cmd;
  logic [DW-1:0]     rsp_data, prdata;
  logic              rsp_err, m_cmd_vld, m_cmd_rdy;
  logic              psel, penable, pready, pslverr, busy;
  logic [CW-1:0]     m_cmd;
  logic [CW-1:0]     cmds [NR];
  int                n_tests = 0;
  int                n_fail  = 0;
  int                last_m;

  always #5 pclk = ~pclk;

  always_comb begin
    req_cmd = '0;
    for (int k = 0; k < NR; k++) req_cmd[k*CW +: CW] = cmds[k];
  end

  apb_cmd_arbiter #(
    .NUM_REQ        (NR),
    .CMD_RW_WIDTH   (RW),
    .CMD_ADDR_WIDTH (AW),
    .CMD_DATA_WIDTH (DW),
    .TIMEOUT_CYC    (TMO)
  ) dut (
    .pclk_i        (pclk),
    .prst_n_i      (prst_n),
    .req_vld_i     (req_vld),
    .req_cmd_i     (req_cmd),
    .req_rdy_o     (req_rdy),
    .rsp_vld_o     (rsp_vld),
    .rsp_data_o    (rsp_data),
    .rsp_err_o     (rsp_err),
    .m_cmd_o       (m_cmd),
    .m_cmd_vld_o   (m_cmd_vld),
    .m_cmd_rdy_i   (m_cmd_rdy),
    .apb_psel_i    (psel),
    .apb_penable_i (penable),
    .apb_pready_i  (pready),
    .apb_pslverr_i (pslverr),
    .apb_prdata_i  (prdata),
    .busy_o        (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic bus_idle();
    psel    = 1'b0;
    penable = 1'b0;
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = $urandom;
  endtask

  // Any bus pattern except a full completion beat.
  task automatic bus_noise();
    logic [2:0] x;
    x = 3'($urandom_range(0, 6));
    {psel, penable, pready} = x;
    pslverr = 1'($urandom);
    prdata  = $urandom;
  endtask

  function automatic logic [CW-1:0] rand_cmd();
    return {8'($urandom_range(0, 1)), 16'($urandom), 32'($urandom)};
  endfunction

  function automatic int model_pick(input logic [NR-1:0] v, input int last);
    for (int k = 1; k <= NR; k++) begin
      int idx;
      idx = (last + k) % NR;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic do_reset();
    prst_n    = 1'b0;
    req_vld   = '0;
    m_cmd_rdy = 1'b0;
    bus_idle();
    tick();
    tick();
    prst_n = 1'b1;
    last_m = NR - 1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_rdy"},   64'(req_rdy),   0);
    check({tag, "_rsp_vld"},   64'(rsp_vld),   0);
    check({tag, "_rsp_data"},  64'(rsp_data),  0);
    check({tag, "_rsp_err"},   64'(rsp_err),   0);
    check({tag, "_m_cmd"},     64'(m_cmd),     0);
    check({tag, "_m_cmd_vld"}, 64'(m_cmd_vld), 0);
    check({tag, "_busy"},      64'(busy),      0);
  endtask

  // Drives one complete transaction starting in IDLE. beat_at >= TMO means no beat.
  task automatic run_txn(input logic [NR-1:0] vld, input int exp_g, input int rdy_dly,
                         input int beat_at, input logic slverr, input logic [DW-1:0] rdata,
                         input bit spurious);
    int            g, r;
    logic [CW-1:0] exp_cmd;
    logic [DW-1:0] exp_data;
    logic          exp_err;
    g        = (exp_g >= 0) ? exp_g : model_pick(vld, last_m);
    exp_cmd  = cmds[g];
    r        = (beat_at < TMO) ? beat_at + 1 : TMO;
    exp_data = (beat_at < TMO) ? rdata : '0;
    exp_err  = (beat_at < TMO) ? slverr : 1'b1;

    req_vld = vld;
    #1;
    check("accept_rdy", 64'(req_rdy), 64'(NR'(1) << g));
    check("idle_busy", 64'(busy), 0);
    tick();

    for (int i = 0; i < rdy_dly; i++) begin
      if (spurious && i == 0) begin
        psel = 1'b1; penable = 1'b1; pready = 1'b1; pslverr = 1'b1; prdata = 32'hBAD0BAD0;
      end
      #1;
      check("issue_vld", 64'(m_cmd_vld), 1);
      check("issue_cmd", 64'(m_cmd), 64'(exp_cmd));
      tick();
      bus_idle();
    end
    m_cmd_rdy = 1'b1;
    #1;
    check("issue_vld", 64'(m_cmd_vld), 1);
    check("issue_cmd", 64'(m_cmd), 64'(exp_cmd));
    check("issue_busy", 64'(busy), 1);
    tick();
    m_cmd_rdy = 1'b0;

    for (int i = 0; i < r; i++) begin
      if (i == beat_at) begin
        psel = 1'b1; penable = 1'b1; pready = 1'b1; pslverr = slverr; prdata = rdata;
      end else begin
        bus_noise();
      end
      #1;
      check("wait_no_rsp", 64'(rsp_vld), 0);
      if (i == 0) check("wait_cmd_vld_low", 64'(m_cmd_vld), 0);
      tick();
    end

    bus_noise();
    #1;
    check("rsp_vld", 64'(rsp_vld), 64'(NR'(1) << g));
    check("rsp_data", 64'(rsp_data), 64'(exp_data));
    check("rsp_err", 64'(rsp_err), 64'(exp_err));
    last_m = g;
    tick();
    bus_idle();
    #1;
    check("post_rsp_busy", 64'(busy), 0);
    check("post_rsp_vld", 64'(rsp_vld), 0);
    check("rsp_data_hold", 64'(rsp_data), 64'(exp_data));
    check("rsp_err_hold", 64'(rsp_err), 64'(exp_err));
  endtask

  initial begin
    int fair_a [6];
    int fair_b [4];
    fair_a = '{0, 1, 2, 3, 0, 1};
    fair_b = '{2, 3, 0, 2};
    for (int k = 0; k < NR; k++) cmds[k] = '0;

    do_reset();
    #1;
    check_all_zero("reset");

    // Write from requester 0
    cmds[0] = 56'h01_0010_DEADBEEF;
    run_txn(4'b0001, 0, 2, 1, 1'b0, $urandom, 1'b0);

    // Read from requester 2, with a stray beat during ISSUE
    cmds[2] = {8'h00, 16'h0204, 32'($urandom)};
    run_txn(4'b0100, 2, 1, 0, 1'b0, 32'h12345678, 1'b1);

    // Fairness from reset, then requester 1 drops out
    do_reset();
    for (int n = 0; n < 6; n++) begin
      for (int k = 0; k < NR; k++) cmds[k] = rand_cmd();
      run_txn(4'b1111, fair_a[n], 0, 0, 1'b0, $urandom, 1'b0);
    end
    for (int n = 0; n < 4; n++) begin
      for (int k = 0; k < NR; k++) cmds[k] = rand_cmd();
      run_txn(4'b1101, fair_b[n], 0, 0, 1'b0, $urandom, 1'b0);
    end

    // Timeout with no beat
    cmds[1] = rand_cmd();
    run_txn(4'b0010, -1, 1, TMO, 1'b0, $urandom, 1'b0);

    // Slave error
    cmds[3] = rand_cmd();
    run_txn(4'b1000, -1, 0, 2, 1'b1, 32'hA5A5A5A5, 1'b0);

    // Reset while in WAIT
    cmds[0] = rand_cmd();
    req_vld = 4'b0001;
    #1;
    check("mid_accept_rdy", 64'(req_rdy), 64'(4'b0001));
    tick();
    req_vld   = '0;
    m_cmd_rdy = 1'b1;
    tick();
    m_cmd_rdy = 1'b0;
    tick();
    tick();
    prst_n = 1'b0;
    tick();
    prst_n = 1'b1;
    last_m = NR - 1;
    #1;
    check_all_zero("mid_reset");
    for (int n = 0; n < 3; n++) begin
      tick();
      check("mid_reset_no_rsp", 64'(rsp_vld), 0);
      check("mid_reset_idle", 64'(busy), 0);
    end
    cmds[0] = rand_cmd();
    cmds[3] = rand_cmd();
    run_txn(4'b1001, 0, 0, 0, 1'b0, $urandom, 1'b0);

    // Beat on the last timeout cycle is a real completion
    cmds[3] = rand_cmd();
    run_txn(4'b1000, -1, 0, TMO - 1, 1'b0, 32'h5A5A0F0F, 1'b0);
    cmds[0] = rand_cmd();
    run_txn(4'b0001, -1, 0, TMO - 1, 1'b1, 32'h0000C0DE, 1'b0);

    // Randomized traffic against the transaction model
    for (int n = 0; n < 24; n++) begin
      logic [NR-1:0] v;
      if ($urandom_range(0, 3) == 0) begin
        req_vld = '0;
        #1;
        check("idle_gap_rdy", 64'(req_rdy), 0);
        tick();
      end
      for (int k = 0; k < NR; k++) cmds[k] = rand_cmd();
      v = NR'($urandom_range(1, (1 << NR) - 1));
      run_txn(v, -1, $urandom_range(0, 3), $urandom_range(0, TMO + 1), 1'($urandom),
              $urandom, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
